// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-to-binary arbiter slice.
package gray_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] gray_word_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // True when exactly one bit of x is set.
  function automatic logic is_pop_one(input gray_word_t x);
    return (x != '0) && ((x & (x - gray_word_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter, MSB-first XOR chain.
module gray2bin #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    bin_o[WIDTH-1] = gray_i[WIDTH-1];
    for (int k = int'(WIDTH) - 2; k >= 0; k--) begin
      bin_o[k] = bin_o[k+1] ^ gray_i[k];
    end
  end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin shared Gray-to-binary converter with a one-deep tagged output register.
// Optional per-requester Gray sequence check enabled by GRAY_SEQ_CHECK_EN.
module gray_decode_arbiter
  import gray_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  input  logic                   out_ready,
  output logic                   out_err
);

  out_state_e        state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              can_load;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic              xfer;
  logic [WIDTH-1:0]  sel_word;
  logic [WIDTH-1:0]  sel_bin;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    return ID_W'((32'(base) + off) % N_REQ);
  endfunction

  assign can_load = (state_q == OUT_EMPTY) || out_ready;

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid[wrap_idx(rr_ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (win_found && can_load && !rst) begin
      req_ready = N_REQ'(1) << win_idx;
    end
  end

  assign xfer     = |req_ready;
  assign sel_word = req_data[32'(win_idx)*WIDTH +: WIDTH];

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray_i (sel_word),
    .bin_o  (sel_bin)
  );

  // Output register next state: load wins over drain so there is no bubble.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d  = OUT_FULL;
      data_d   = sel_bin;
      id_d     = win_idx;
      rr_ptr_d = wrap_idx(win_idx, 1);
    end else if ((state_q == OUT_FULL) && out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OUT_EMPTY;
      data_q   <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

`ifdef GRAY_SEQ_CHECK_EN
  logic [WIDTH-1:0] last_g_q [N_REQ];
  logic [N_REQ-1:0] seen_q;
  logic             err_q, err_d;
  logic [WIDTH-1:0] diff;

  assign diff = sel_word ^ last_g_q[win_idx];

  // A legal Gray successor differs from the previous word in exactly one bit.
  always_comb begin
    err_d = err_q;
    if (xfer) begin
      err_d = seen_q[win_idx] && !is_pop_one(gray_word_t'(diff));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      seen_q <= '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        last_g_q[k] <= '0;
      end
    end else begin
      err_q <= err_d;
      if (xfer) begin
        last_g_q[win_idx] <= sel_word;
        seen_q[win_idx]   <= 1'b1;
      end
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule
